// File: rtl/spike_pkg.sv
// Shared definitions for the spike time decoder: window length, the
// spike time type, the decoder state encoding and a saturating increment.
// The window length comes from the `TIME_PERIOD macro; a 16-step window is
// assumed when the macro has not been defined by the build.

`ifndef TIME_PERIOD
`define TIME_PERIOD 16
`endif

package spike_pkg;

    localparam int TP = `TIME_PERIOD;
    localparam int TW = (TP > 1) ? $clog2(TP) : 1;

    typedef logic [TW-1:0] spike_time_t;

    localparam spike_time_t CNT_MAX   = '1;
    localparam spike_time_t LAST_STEP = spike_time_t'(TP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // Count up by one, but stick at the all-ones value instead of wrapping.
    function automatic spike_time_t sat_inc(input spike_time_t value);
        return (value == CNT_MAX) ? value : value + spike_time_t'(1);
    endfunction

endpackage

// File: rtl/spike_ch_counter.sv
// One decoder channel: counts the high samples of its spike line during a
// window, saturating at the top of the spike time range. With
// SPIKE_DEC_ERR_EN defined it also remembers whether a low sample has been
// seen and flags any spike that breaks the thermometer shape.
// The *_next outputs already include the current cycle's sample so the
// parent can capture the final result on the last window step.

import spike_pkg::*;

module spike_ch_counter (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        clear,
    input  logic        sample_en,
    input  logic        spike,
`ifdef SPIKE_DEC_ERR_EN
    input  logic        last,
    output logic        err_next,
`endif
    output spike_time_t cnt_next
);

    spike_time_t cnt;

    // Next count: one more for every high sample, never wrapping.
    always_comb begin
        cnt_next = cnt;
        if (sample_en && spike) begin
            cnt_next = sat_inc(cnt);
        end
    end

    // Count register, zeroed at reset and at the start of every window.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (sample_en) begin
            cnt <= cnt_next;
        end
    end

`ifdef SPIKE_DEC_ERR_EN
    logic seen_low;
    logic err;

    // A spike after a low sample, or a spike still high on the last step,
    // cannot come from a legal thermometer-coded train.
    always_comb begin
        err_next = err | (sample_en & spike & (seen_low | last));
    end

    // Sticky low-seen and error flags, cleared with the counter.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            seen_low <= 1'b0;
            err      <= 1'b0;
        end else if (clear) begin
            seen_low <= 1'b0;
            err      <= 1'b0;
        end else if (sample_en) begin
            seen_low <= seen_low | ~spike;
            err      <= err_next;
        end
    end
`endif

endmodule

// File: rtl/spike_time_decoder.sv
// Receive-side spike time decoder. Runs one coding window of TP steps,
// broadcasts the current step on time_val, counts the high cycles on each
// of NUM_CH spike lines and hands the recovered spike times to the next
// layer over a valid/ready handshake.
// Optional feature macro: SPIKE_DEC_ERR_EN enables per-channel
// thermometer-violation flags on out_err; otherwise out_err is tied to 0.

import spike_pkg::*;

module spike_time_decoder #(
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    spike_in,
    output logic [TW-1:0]        time_val,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CH*TW-1:0] out_spike_time,
    output logic [NUM_CH-1:0]    out_err
);

    dec_state_t state;

    logic                 sample_en;
    logic                 last_step;
    logic                 clear_cnt;
    logic [NUM_CH*TW-1:0] final_cnt;
`ifdef SPIKE_DEC_ERR_EN
    logic [NUM_CH-1:0]    final_err;
`endif

    // Channels sample only in RUN; counters restart whenever a new window
    // is accepted, either from IDLE or straight out of DONE.
    always_comb begin
        sample_en = (state == RUN);
        last_step = (state == RUN) && (time_val == LAST_STEP);
        clear_cnt = start && ((state == IDLE) || ((state == DONE) && out_ready));
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        spike_ch_counter u_cnt (
            .clk      (clk),
            .rst_l    (rst_l),
            .clear    (clear_cnt),
            .sample_en(sample_en),
            .spike    (spike_in[ch]),
`ifdef SPIKE_DEC_ERR_EN
            .last     (last_step),
            .err_next (final_err[ch]),
`endif
            .cnt_next (final_cnt[ch*TW +: TW])
        );
    end

`ifndef SPIKE_DEC_ERR_EN
    assign out_err = '0;
`endif

    // Window sequencer with registered busy/valid/result outputs.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state          <= IDLE;
            time_val       <= '0;
            busy           <= 1'b0;
            out_valid      <= 1'b0;
            out_spike_time <= '0;
`ifdef SPIKE_DEC_ERR_EN
            out_err        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    time_val <= '0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        state          <= DONE;
                        time_val       <= '0;
                        busy           <= 1'b0;
                        out_valid      <= 1'b1;
                        out_spike_time <= final_cnt;
`ifdef SPIKE_DEC_ERR_EN
                        out_err        <= final_err;
`endif
                    end else begin
                        time_val <= time_val + spike_time_t'(1);
                    end
                end
                DONE: begin
                    time_val <= '0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    time_val  <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_time_decoder.sv
// Directed testbench for spike_time_decoder with a 16-step window and four
// channels. Inputs change and outputs are sampled on the falling clock edge.
// Expected error flags depend on whether SPIKE_DEC_ERR_EN is defined.

import spike_pkg::*;

module tb_spike_time_decoder;

    localparam int NUM_CH = 4;

    logic                 clk;
    logic                 rst_l;
    logic                 start;
    logic [NUM_CH-1:0]    spike_in;
    logic [TW-1:0]        time_val;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_CH*TW-1:0] out_spike_time;
    logic [NUM_CH-1:0]    out_err;

    int checks_total;
    int checks_passed;

    spike_time_decoder #(.NUM_CH(NUM_CH)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .start         (start),
        .spike_in      (spike_in),
        .time_val      (time_val),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_spike_time(out_spike_time),
        .out_err       (out_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before time 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_window();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the falling edge of the first RUN cycle. Drives the masks
    // (bit t = spike at step t), optionally pulses start at step 7, then
    // checks the result one cycle after the last step.
    task automatic drive_window(input logic [15:0] m0, input logic [15:0] m1,
                                input logic [15:0] m2, input logic [15:0] m3,
                                input logic start_at_7,
                                input logic [15:0] exp_time,
                                input logic [3:0] exp_err,
                                input string name);
        for (int t = 0; t < 16; t++) begin
            if (t > 0) @(negedge clk);
            checks_total++;
            if (time_val !== spike_time_t'(t) || busy !== 1'b1) begin
                $display("[TB] FAIL %s step %0d: time_val=%0d busy=%b, required time_val=%0d busy=1",
                         name, t, time_val, busy, t);
            end else begin
                checks_passed++;
            end
            spike_in = {m3[t], m2[t], m1[t], m0[t]};
            start    = start_at_7 && (t == 7);
        end
        @(negedge clk);
        spike_in = '0;
        start    = 1'b0;
        checks_total++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || time_val !== '0) begin
            $display("[TB] FAIL %s handshake: valid=%b busy=%b time_val=%0d, required valid=1 busy=0 time_val=0",
                     name, out_valid, busy, time_val);
        end else begin
            checks_passed++;
        end
        checks_total++;
        if (out_spike_time !== exp_time) begin
            $display("[TB] FAIL %s spike_time: got %h, required %h", name, out_spike_time, exp_time);
        end else begin
            checks_passed++;
        end
        checks_total++;
        if (out_err !== exp_err) begin
            $display("[TB] FAIL %s err: got %b, required %b", name, out_err, exp_err);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_reset();
        rst_l     = 1'b0;
        start     = 1'b0;
        spike_in  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || time_val !== '0 ||
            out_spike_time !== '0 || out_err !== '0) begin
            $display("[TB] FAIL reset: busy=%b valid=%b time_val=%0d spike_time=%h err=%b, required all zero",
                     busy, out_valid, time_val, out_spike_time, out_err);
        end else begin
            checks_passed++;
        end
        rst_l = 1'b1;
        @(negedge clk);
        checks_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, out_valid);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_basic();
        start_window();
        drive_window(16'h001F, 16'h0000, 16'h7FFF, 16'h0001, 1'b0, 16'h1F05, 4'b0000, "basic");
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks_total++;
            if (out_valid !== 1'b1 || out_spike_time !== 16'h1F05 || out_err !== 4'b0000) begin
                $display("[TB] FAIL hold cycle %0d: valid=%b spike_time=%h err=%b, required 1 1f05 0000",
                         i, out_valid, out_spike_time, out_err);
            end else begin
                checks_passed++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL ack_to_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
        end else begin
            checks_passed++;
        end
        @(negedge clk);
        checks_total++;
        if (busy !== 1'b0 || time_val !== '0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL stay_idle: busy=%b time_val=%0d valid=%b, required 0 0 0",
                     busy, time_val, out_valid);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        start_window();
        drive_window(16'h0007, 16'h007F, 16'h0003, 16'h01FF, 1'b0, 16'h9273, 4'b0000, "b2b_first");
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        checks_total++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || time_val !== '0) begin
            $display("[TB] FAIL b2b_restart: valid=%b busy=%b time_val=%0d, required 0 1 0",
                     out_valid, busy, time_val);
        end else begin
            checks_passed++;
        end
        drive_window(16'h0FFF, 16'h000F, 16'h0000, 16'h00FF, 1'b0, 16'h804C, 4'b0000, "b2b_second");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_err();
        logic [3:0] exp_err;
`ifdef SPIKE_DEC_ERR_EN
        exp_err = 4'b0011;
`else
        exp_err = 4'b0000;
`endif
        start_window();
        drive_window(16'h0047, 16'hFFFF, 16'h03FF, 16'h0000, 1'b0, 16'h0AF4, exp_err, "err");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        start_window();
        out_ready = 1'b1;
        drive_window(16'h0003, 16'h0003, 16'h0003, 16'h0003, 1'b1, 16'h2222, 4'b0000, "start_ignored");
        @(negedge clk);
        out_ready = 1'b0;
        checks_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL no_queued_start: valid=%b busy=%b, required 0 0", out_valid, busy);
        end else begin
            checks_passed++;
        end
        @(negedge clk);
        checks_total++;
        if (busy !== 1'b0 || time_val !== '0) begin
            $display("[TB] FAIL still_idle: busy=%b time_val=%0d, required 0 0", busy, time_val);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        start_window();
        for (int t = 0; t <= 8; t++) begin
            if (t > 0) @(negedge clk);
            spike_in = 4'b1111;
        end
        rst_l = 1'b0;
        @(negedge clk);
        spike_in = '0;
        checks_total++;
        if (busy !== 1'b0 || time_val !== '0 || out_valid !== 1'b0 || out_spike_time !== '0) begin
            $display("[TB] FAIL reset_mid_run: busy=%b time_val=%0d valid=%b spike_time=%h, required 0 0 0 0000",
                     busy, time_val, out_valid, out_spike_time);
        end else begin
            checks_passed++;
        end
        rst_l = 1'b1;
        start_window();
        drive_window(16'h003F, 16'h0001, 16'h0000, 16'h0007, 1'b0, 16'h3016, 4'b0000, "after_reset");
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        checks_total++;
        if (out_valid !== 1'b0 || out_spike_time !== '0 || busy !== 1'b0) begin
            $display("[TB] FAIL reset_mid_done: valid=%b spike_time=%h busy=%b, required 0 0000 0",
                     out_valid, out_spike_time, busy);
        end else begin
            checks_passed++;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        $display("[TB] spike_time_decoder directed test, TP=%0d TW=%0d", TP, TW);
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_err();
        test_start_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
